mill_modif_enc: RTL and testbench

- Modified Miller encoder: the transmit-side counterpart of the Modified Miller decoder (ISO 14443 Type A reader-to-card, 106 kb/s).
- Takes an NRZ-L bit stream over a valid/ready handshake, adds start-of-communication (SoC) and end-of-communication (EoC).
- Drives a registered pause signal that gates the carrier modulator.
- Clocked at fc/16 (847.5 kHz); each ETU lasts ETU_CLKS clocks.

---
 rtl/mill_modif_enc_if.sv | 13 +
 rtl/mill_modif_enc.sv | 98 +++++++++
 tb/tb_mill_modif_enc.sv | 115 +++++++++++
 3 files changed

// File: rtl/mill_modif_enc_if.sv
// mill_modif_enc_if: NRZ-L bit handshake plus pause/status outputs of the Modified Miller encoder.
interface mill_modif_enc_if;
    logic in_valid;
    logic in_data;
    logic in_last;
    logic in_ready;
    logic out_pause;
    logic out_busy;
    logic out_done;
    logic out_err;
    modport master (output in_valid, in_data, in_last, input in_ready, out_pause, out_busy, out_done, out_err);
    modport slave (input in_valid, in_data, in_last, output in_ready, out_pause, out_busy, out_done, out_err);
endinterface

// File: rtl/mill_modif_enc.sv
// mill_modif_enc: ISO 14443A Modified Miller encoder, NRZ-L bits in, registered carrier pause out.
module mill_modif_enc #(
    parameter int ETU_CLKS   = 8,
    parameter int PAUSE_CLKS = 2,
    parameter int CW         = 4
) (
    input logic              clk,
    input logic              rst_n,
    mill_modif_enc_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SOC, DATA, EOC0, EOCY, DONE} state_t;
    typedef enum logic [1:0] {SYM_Y, SYM_X, SYM_Z} sym_t;
    localparam logic [CW-1:0] K_LAST = CW'(ETU_CLKS - 1);
    localparam logic [CW-1:0] K_HALF = CW'(ETU_CLKS / 2);
    localparam logic [CW-1:0] K_P    = CW'(PAUSE_CLKS);
    localparam logic [CW-1:0] K_HP   = CW'(ETU_CLKS / 2 + PAUSE_CLKS);
    state_t        state_q, state_d;
    sym_t          sym_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_q, bit_d, last_q, last_d, prevx_q, prevx_d;
    logic          pause_q, pause_d, busy_q, done_q, err_q;
    logic          end_k, xfer;
    assign end_k        = cnt_q == K_LAST;
    assign bus.in_ready = state_q == IDLE || (state_q == DATA && end_k && !last_q);
    assign xfer         = bus.in_valid && bus.in_ready;
    always_comb begin
        state_d = state_q;
        cnt_d   = end_k ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        last_d  = last_q;
        prevx_d = prevx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (xfer) begin
                    state_d = SOC;
                    bit_d   = bus.in_data;
                    last_d  = bus.in_last;
                end
            end
            SOC: if (end_k) begin
                state_d = DATA;
                prevx_d = 1'b0;
            end
            // the finished symbol was X exactly when the held bit was 1
            DATA: if (end_k) begin
                prevx_d = bit_q;
                if (xfer) begin
                    bit_d  = bus.in_data;
                    last_d = bus.in_last;
                end else begin
                    state_d = EOC0;
                end
            end
            EOC0: if (end_k) state_d = EOCY;
            EOCY: if (end_k) state_d = DONE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = 1'b0;
                last_d  = 1'b0;
                prevx_d = 1'b0;
            end
        endcase
        sym_d   = state_d == SOC ? SYM_Z :
                  (state_d == DATA && bit_d) ? SYM_X :
                  (state_d == DATA || state_d == EOC0) ? (prevx_d ? SYM_Y : SYM_Z) : SYM_Y;
        pause_d = (sym_d == SYM_Z && cnt_d < K_P) ||
                  (sym_d == SYM_X && cnt_d >= K_HALF && cnt_d < K_HP);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
            prevx_q <= 1'b0;
            pause_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            prevx_q <= prevx_d;
            pause_q <= pause_d;
            busy_q  <= state_d inside {SOC, DATA, EOC0, EOCY};
            done_q  <= state_d == DONE;
            err_q   <= state_q == DATA && end_k && !last_q && !bus.in_valid;
        end
    end
    assign bus.out_pause = pause_q;
    assign bus.out_busy  = busy_q;
    assign bus.out_done  = done_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_mill_modif_enc.sv
// tb_mill_modif_enc: scoreboard bench; a symbol-level model queues expected per-cycle outputs per frame.
module tb_mill_modif_enc;
    logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic valid = 1'b0, data = 1'b0, last = 1'b0;
    int checks = 0, failures = 0, fr = 0;
    logic [4:0] sb[$];
    always #5 clk = ~clk;
    mill_modif_enc_if ifa ();
    mill_modif_enc_if ifb ();
    assign ifa.in_valid = !sel && valid;
    assign ifa.in_data  = data;
    assign ifa.in_last  = last;
    assign ifb.in_valid = sel && valid;
    assign ifb.in_data  = data;
    assign ifb.in_last  = last;
    mill_modif_enc #(.ETU_CLKS(8), .PAUSE_CLKS(2), .CW(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    mill_modif_enc #(.ETU_CLKS(16), .PAUSE_CLKS(3), .CW(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    // {pause, ready, busy, done, err} of the selected encoder
    wire [4:0] obs = sel ? {ifb.out_pause, ifb.in_ready, ifb.out_busy, ifb.out_done, ifb.out_err}
                         : {ifa.out_pause, ifa.in_ready, ifa.out_busy, ifa.out_done, ifa.out_err};
    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b (pause,ready,busy,done,err)", tag, got, exp);
        end
    endtask
    // u >= 0: underrun at the fetch after bit u; hold: keep valid high through DONE with the next frame's first bit
    task automatic run_frame(input logic s, input logic [15:0] b, input int n, input int u,
                             input logic hold, input logic hold_d, input logic hold_l);
        int etu, pc, h, ns, tot, idx, k;
        logic [1:0] sym[20];
        logic px, p, r, e;
        etu = s ? 16 : 8;
        pc  = s ? 3 : 2;
        h   = etu / 2;
        ns  = u >= 0 ? u + 1 : n;
        tot = (ns + 3) * etu;
        px  = 1'b0;
        sym[0] = 2'd2;
        for (int i = 0; i < ns; i++) begin
            sym[i+1] = b[i] ? 2'd1 : (px ? 2'd0 : 2'd2);
            px = b[i];
        end
        sym[ns+1] = px ? 2'd0 : 2'd2;
        sym[ns+2] = 2'd0;
        for (int c = 0; c <= tot; c++) begin
            if (c == tot) sb.push_back(5'b00010);
            else begin
                idx = c / etu;
                k   = c % etu;
                p = (sym[idx] == 2'd2 && k < pc) || (sym[idx] == 2'd1 && k >= h && k < h + pc);
                r = k == etu - 1 && idx >= 1 && idx <= ns && !(u < 0 && idx == n);
                e = u >= 0 && c == (ns + 1) * etu;
                sb.push_back({p, r, 1'b1, 1'b0, e});
            end
        end
        sel   = s;
        valid = 1'b1;
        data  = b[0];
        last  = u < 0 && n == 1;
        @(posedge clk);
        for (int c = 0; c <= tot; c++) begin
            @(negedge clk);
            check($sformatf("f%0d_c%0d", fr, c), obs, sb.pop_front());
            idx = c / etu;
            k   = c % etu;
            if (c == tot) {valid, data, last} = {hold, hold_d, hold_l};
            else if (k == etu - 1 && idx >= 1 && idx < ns) {valid, data, last} = {1'b1, b[idx], u < 0 && idx == n - 1};
            else if (k == etu - 1 && idx == ns && u >= 0) {valid, data, last} = {1'b0, 2'($urandom)};
            else {valid, data, last} = 3'($urandom);
        end
        @(posedge clk);
        @(negedge clk);
        check($sformatf("f%0d_idle", fr), obs, 5'b01000);
        fr++;
    endtask
    initial begin
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {valid, data, last} = 3'($urandom);
            sel = 1'b0;
            #1 check("rst_a", obs, 5'b01000);
            sel = 1'b1;
            #1 check("rst_b", obs, 5'b01000);
        end
        @(negedge clk);
        {sel, valid} = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst", obs, 5'b01000);
        {valid, data, last} = 3'b111;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check("soc_c1", obs, 5'b10100);
        #2 rst_n = 1'b0;
        #1 check("async_rst", obs, 5'b01000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_idle", obs, 5'b01000);
        run_frame(1'b0, 16'h0001, 1, -1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 16'h000c, 5, -1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 16'h0001, 1, 0, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 16'h0001, 2, -1, 1'b1, 1'b1, 1'b1);
        run_frame(1'b0, 16'h0001, 1, -1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 16'h0001, 1, -1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 16'($urandom), 7, -1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 16'h0016, 5, 2, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
